motor_pwm_drive: RTL and testbench

//  Dual H-bridge drive controller: takes buttons or a registered motion command and drives two
//  H-bridge legs (left = 1a/1b, right = 2a/2b).

---
 rtl/motor_pwm_drive.sv | 214 +++++++++++++++++++++
 tb/tb_motor_pwm_drive.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_drive.sv
// Dual H-bridge drive controller: picks a button or command target, applies PWM with a
// soft-start ramp, and holds all bridge pins low for a dead interval on direction reversal.
module motor_pwm_drive #(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned PWM_DIV     = 1,
   parameter int unsigned DEAD_CYCLES = 1000,
   parameter int unsigned RAMP_STEP   = 4,
   parameter int unsigned BTN_DUTY    = 2**PWM_BITS - 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                btnU,
   input  logic                btnD,
   input  logic                btnL,
   input  logic                btnR,
   input  logic                cmd_valid,
   input  logic [2:0]          cmd_dir,
   input  logic [PWM_BITS-1:0] cmd_duty,
   output logic                cmd_ready,
   output logic                hbridge1a,
   output logic                hbridge1b,
   output logic                hbridge2a,
   output logic                hbridge2b,
   output logic                busy,
   output logic [2:0]          cur_dir
);

   localparam int unsigned DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam int unsigned SUM_W  = PWM_BITS + 1;
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [2:0] DIR_STOP  = 3'd0;
   localparam logic [2:0] DIR_FWD   = 3'd1;
   localparam logic [2:0] DIR_BACK  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_cur_dir;
   logic [2:0]          w_dir_nxt;
   logic [PWM_BITS-1:0] r_cur_duty;
   logic [PWM_BITS-1:0] w_duty_nxt;
   logic [DEAD_W-1:0]   r_dead_cnt;
   logic [DEAD_W-1:0]   w_dead_nxt;
   logic [2:0]          r_cmd_dir;
   logic [PWM_BITS-1:0] r_cmd_duty;
   logic [DIV_W-1:0]    r_presc;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [3:0]          r_pins;
   logic [3:0]          w_pins;
   logic                r_busy;
   logic                r_cmd_ready;

   logic                w_presc_wrap;
   logic                w_period_wrap;
   logic                w_pwm_on;
   logic [2:0]          w_tgt_dir;
   logic [PWM_BITS-1:0] w_tgt_duty;
   logic [SUM_W-1:0]    w_ramp_sum;
   logic [PWM_BITS-1:0] w_ramp_duty;

   assign w_presc_wrap  = (r_presc == DIV_W'(PWM_DIV - 1));
   assign w_period_wrap = w_presc_wrap && (r_pwm_cnt == DUTY_MAX);
   assign w_pwm_on      = (r_cur_duty == DUTY_MAX) || (r_pwm_cnt < r_cur_duty);

   // Free-running PWM timebase, never disturbed by state changes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc   <= '0;
         r_pwm_cnt <= '0;
      end else begin
         if (w_presc_wrap) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
         end else begin
            r_presc   <= r_presc + 1'b1;
         end
      end
   end

   // Target: held buttons win (U>D>L>R) at full button duty, else the command register
   always_comb begin
      w_tgt_dir  = DIR_STOP;
      w_tgt_duty = r_cmd_duty;
      if (btnU) begin
         w_tgt_dir  = DIR_FWD;
         w_tgt_duty = PWM_BITS'(BTN_DUTY);
      end else if (btnD) begin
         w_tgt_dir  = DIR_BACK;
         w_tgt_duty = PWM_BITS'(BTN_DUTY);
      end else if (btnL) begin
         w_tgt_dir  = DIR_LEFT;
         w_tgt_duty = PWM_BITS'(BTN_DUTY);
      end else if (btnR) begin
         w_tgt_dir  = DIR_RIGHT;
         w_tgt_duty = PWM_BITS'(BTN_DUTY);
      end else if ((r_cmd_dir >= DIR_FWD) && (r_cmd_dir <= DIR_RIGHT)) begin
         w_tgt_dir  = r_cmd_dir;
      end
   end

   // Ramp step is summed one bit wider so it saturates at the target instead of wrapping
   assign w_ramp_sum  = SUM_W'(r_cur_duty) + SUM_W'(RAMP_STEP);
   assign w_ramp_duty = (w_ramp_sum > SUM_W'(w_tgt_duty)) ? w_tgt_duty
                                                          : w_ramp_sum[PWM_BITS-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_cur_dir;
      w_duty_nxt  = r_cur_duty;
      w_dead_nxt  = r_dead_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_tgt_dir != DIR_STOP) begin
               w_state_nxt = S_RUN;
               w_dir_nxt   = w_tgt_dir;
               w_duty_nxt  = '0;
            end
         end
         S_RUN: begin
            if (w_tgt_dir == r_cur_dir) begin
               if (w_tgt_duty < r_cur_duty) begin
                  w_duty_nxt = w_tgt_duty;
               end else if (w_period_wrap && (r_cur_duty < w_tgt_duty)) begin
                  w_duty_nxt = w_ramp_duty;
               end
            end else if (w_tgt_dir == DIR_STOP) begin
               w_state_nxt = S_IDLE;
               w_dir_nxt   = DIR_STOP;
               w_duty_nxt  = '0;
            end else begin
               w_state_nxt = S_DEAD;
               w_dir_nxt   = DIR_STOP;
               w_duty_nxt  = '0;
               w_dead_nxt  = DEAD_W'(DEAD_CYCLES - 1);
            end
         end
         S_DEAD: begin
            if (r_dead_cnt == '0) begin
               if (w_tgt_dir != DIR_STOP) begin
                  w_state_nxt = S_RUN;
                  w_dir_nxt   = w_tgt_dir;
               end else begin
                  w_state_nxt = S_IDLE;
               end
               w_duty_nxt = '0;
            end else begin
               w_dead_nxt = r_dead_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_dir_nxt   = DIR_STOP;
            w_duty_nxt  = '0;
         end
      endcase
   end

   // Pin pattern {1a,1b,2a,2b}; only RUN during the PWM on-phase drives anything
   always_comb begin
      w_pins = 4'b0000;
      if ((r_state == S_RUN) && w_pwm_on) begin
         case (r_cur_dir)
            DIR_FWD:   w_pins = 4'b1010;
            DIR_BACK:  w_pins = 4'b0101;
            DIR_LEFT:  w_pins = 4'b0110;
            DIR_RIGHT: w_pins = 4'b1001;
            default:   w_pins = 4'b0000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cur_dir   <= DIR_STOP;
         r_cur_duty  <= '0;
         r_dead_cnt  <= '0;
         r_cmd_dir   <= DIR_STOP;
         r_cmd_duty  <= '0;
         r_pins      <= 4'b0000;
         r_busy      <= 1'b0;
         r_cmd_ready <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cur_dir   <= w_dir_nxt;
         r_cur_duty  <= w_duty_nxt;
         r_dead_cnt  <= w_dead_nxt;
         r_pins      <= w_pins;
         r_busy      <= (w_state_nxt == S_DEAD);
         r_cmd_ready <= (w_state_nxt != S_DEAD);
         if (cmd_valid && r_cmd_ready) begin
            r_cmd_dir  <= cmd_dir;
            r_cmd_duty <= cmd_duty;
         end
      end
   end

   assign hbridge1a = r_pins[3];
   assign hbridge1b = r_pins[2];
   assign hbridge2a = r_pins[1];
   assign hbridge2b = r_pins[0];
   assign busy      = r_busy;
   assign cmd_ready = r_cmd_ready;
   assign cur_dir   = r_cur_dir;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Bench for motor_pwm_drive: directed scenarios plus randomized buttons/commands, all
// compared every cycle against a behavioural model of the drive rules.
module tb_motor_pwm_drive;

   localparam int unsigned PWM_BITS    = 4;
   localparam int unsigned PWM_DIV     = 1;
   localparam int unsigned DEAD_CYCLES = 8;
   localparam int unsigned RAMP_STEP   = 4;
   localparam int unsigned BTN_DUTY    = 15;
   localparam int STEPS  = 2**PWM_BITS;
   localparam int PERIOD = PWM_DIV * STEPS;
   localparam int FULL   = STEPS - 1;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DEAD = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                btnU, btnD, btnL, btnR;
   logic                cmd_valid;
   logic [2:0]          cmd_dir;
   logic [PWM_BITS-1:0] cmd_duty;
   logic                cmd_ready;
   logic                hbridge1a, hbridge1b, hbridge2a, hbridge2b;
   logic                busy;
   logic [2:0]          cur_dir;

   int checks = 0;
   int errors = 0;

   motor_pwm_drive #(
      .PWM_BITS(PWM_BITS), .PWM_DIV(PWM_DIV), .DEAD_CYCLES(DEAD_CYCLES),
      .RAMP_STEP(RAMP_STEP), .BTN_DUTY(BTN_DUTY)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
      .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .cmd_ready(cmd_ready),
      .hbridge1a(hbridge1a), .hbridge1b(hbridge1b), .hbridge2a(hbridge2a), .hbridge2b(hbridge2b),
      .busy(busy), .cur_dir(cur_dir)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode/direction/duty as integers, PWM phase derived from elapsed clocks
   int         m_mode, m_dir, m_duty, m_dead, m_cdir, m_cduty, m_tick;
   logic [3:0] m_pins;
   logic       m_busy, m_ready;
   int         t_dir, t_duty, n_mode, n_dir, n_duty, n_dead, phase;
   logic       t_on, t_wrap;

   function automatic logic [3:0] leg_pattern(input int d);
      logic lf, lb, rf, rb;
      lf = (d == 1) || (d == 4);
      lb = (d == 2) || (d == 3);
      rf = (d == 1) || (d == 3);
      rb = (d == 2) || (d == 4);
      return {lf, lb, rf, rb};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= M_IDLE; m_dir <= 0; m_duty <= 0; m_dead <= 0;
         m_cdir <= 0; m_cduty <= 0; m_tick <= 0;
         m_pins <= 4'b0000; m_busy <= 1'b0; m_ready <= 1'b1;
      end else begin
         if (btnU)      t_dir = 1;
         else if (btnD) t_dir = 2;
         else if (btnL) t_dir = 3;
         else if (btnR) t_dir = 4;
         else           t_dir = (m_cdir >= 1 && m_cdir <= 4) ? m_cdir : 0;
         t_duty = (btnU || btnD || btnL || btnR) ? int'(BTN_DUTY) : m_cduty;
         phase  = (m_tick / PWM_DIV) % STEPS;
         t_on   = (m_duty == FULL) || (phase < m_duty);
         t_wrap = ((m_tick + 1) % PERIOD) == 0;
         n_mode = m_mode; n_dir = m_dir; n_duty = m_duty; n_dead = m_dead;
         if (m_mode == M_IDLE) begin
            if (t_dir != 0) begin n_mode = M_RUN; n_dir = t_dir; n_duty = 0; end
         end else if (m_mode == M_RUN) begin
            if (t_dir == m_dir) begin
               if (t_duty < m_duty) n_duty = t_duty;
               else if (t_wrap && m_duty < t_duty)
                  n_duty = (m_duty + int'(RAMP_STEP) > t_duty) ? t_duty : m_duty + int'(RAMP_STEP);
            end else if (t_dir == 0) begin
               n_mode = M_IDLE; n_dir = 0; n_duty = 0;
            end else begin
               n_mode = M_DEAD; n_dir = 0; n_duty = 0; n_dead = int'(DEAD_CYCLES) - 1;
            end
         end else begin
            if (m_dead == 0) begin
               n_mode = (t_dir != 0) ? M_RUN : M_IDLE;
               n_dir  = t_dir;
               n_duty = 0;
            end else begin
               n_dead = m_dead - 1;
            end
         end
         m_pins  <= (m_mode == M_RUN && t_on) ? leg_pattern(m_dir) : 4'b0000;
         m_mode  <= n_mode; m_dir <= n_dir; m_duty <= n_duty; m_dead <= n_dead;
         m_busy  <= (n_mode == M_DEAD);
         m_ready <= (n_mode != M_DEAD);
         m_tick  <= m_tick + 1;
         if (cmd_valid && m_ready) begin
            m_cdir  <= int'(cmd_dir);
            m_cduty <= int'(cmd_duty);
         end
      end
   end

   logic [8:0] obs, m_exp;
   logic [3:0] pins;
   assign pins  = {hbridge1a, hbridge1b, hbridge2a, hbridge2b};
   assign obs   = {pins, busy, cmd_ready, cur_dir};
   assign m_exp = {m_pins, m_busy, m_ready, 3'(m_dir)};

   task automatic test_reset();
      rst_n = 1'b0; btnU = 0; btnD = 0; btnL = 0; btnR = 0;
      cmd_valid = 0; cmd_dir = 3'd0; cmd_duty = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== 9'b0000_0_1_000) begin
         errors++; $display("FAIL reset_state got %b expected %b", obs, 9'b0000_0_1_000);
      end
      rst_n = 1'b1;
      btnU = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== m_exp) begin
            errors++; $display("FAIL model_reset t=%0t got %b expected %b", $time, obs, m_exp);
         end
      end
      checks++;
      if (pins !== 4'b1010) begin
         errors++; $display("FAIL full_on_fwd got %b expected 1010", pins);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 9'b0000_0_1_000) begin
         errors++; $display("FAIL async_reset got %b expected %b", obs, 9'b0000_0_1_000);
      end
      @(negedge clk);
      rst_n = 1'b1; btnU = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== m_exp) begin
            errors++; $display("FAIL model_idle t=%0t got %b expected %b", $time, obs, m_exp);
         end
      end
      checks++;
      if (obs !== 9'b0000_0_1_000) begin
         errors++; $display("FAIL idle_after_reset got %b expected %b", obs, 9'b0000_0_1_000);
      end
   endtask

   task automatic test_ramp();
      int on_cnt;
      on_cnt = 0;
      cmd_valid = 1'b1; cmd_dir = 3'd1; cmd_duty = 4'd8;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         checks++;
         if (obs !== m_exp) begin
            errors++; $display("FAIL model_ramp t=%0t got %b expected %b", $time, obs, m_exp);
         end
         checks++;
         if ({hbridge1b, hbridge2b} !== 2'b00 || hbridge1a !== hbridge2a) begin
            errors++; $display("FAIL fwd_legs t=%0t got %b expected a-legs equal, b-legs 0", $time, pins);
         end
      end
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         if (hbridge1a) on_cnt++;
      end
      checks++;
      if (on_cnt != 8) begin
         errors++; $display("FAIL fwd_duty8_on got %0d expected 8", on_cnt);
      end
   endtask

   task automatic test_reversal();
      int  busy_cnt, back_on;
      logic seen, prev_busy;
      busy_cnt = 0; back_on = 0; seen = 0; prev_busy = 0;
      cmd_valid = 1'b1; cmd_dir = 3'd2; cmd_duty = 4'd8;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         checks++;
         if (obs !== m_exp) begin
            errors++; $display("FAIL model_rev t=%0t got %b expected %b", $time, obs, m_exp);
         end
         if (busy) begin
            busy_cnt++; seen = 1'b1;
            checks++;
            if (cmd_ready !== 1'b0) begin
               errors++; $display("FAIL ready_in_dead got %b expected 0", cmd_ready);
            end
         end
         if (prev_busy) begin
            checks++;
            if (pins !== 4'b0000) begin
               errors++; $display("FAIL dead_pins t=%0t got %b expected 0000", $time, pins);
            end
         end
         prev_busy = busy;
         if (seen && !busy) break;
      end
      checks++;
      if (busy_cnt != 8) begin
         errors++; $display("FAIL dead_len got %0d expected 8", busy_cnt);
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== m_exp || {hbridge1a, hbridge2a} !== 2'b00) begin
            errors++; $display("FAIL model_back t=%0t got %b expected %b", $time, obs, m_exp);
         end
         if (hbridge1b) back_on++;
      end
      checks++;
      if (back_on == 0) begin
         errors++; $display("FAIL back_drive got %0d on-cycles expected nonzero", back_on);
      end
   endtask

   task automatic test_buttons();
      logic saw_busy;
      saw_busy = 0;
      btnU = 1'b1; btnR = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== m_exp) begin
            errors++; $display("FAIL model_btn t=%0t got %b expected %b", $time, obs, m_exp);
         end
         if (i < 3 && busy) saw_busy = 1'b1;
      end
      checks++;
      if (!saw_busy) begin
         errors++; $display("FAIL btn_dead got 0 expected busy within 3 clk");
      end
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         checks++;
         if (pins !== 4'b1010) begin
            errors++; $display("FAIL btn_full_on t=%0t got %b expected 1010", $time, pins);
         end
      end
      btnU = 1'b0; btnR = 1'b0; saw_busy = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== m_exp) begin
            errors++; $display("FAIL model_rel t=%0t got %b expected %b", $time, obs, m_exp);
         end
         if (i < 3 && busy) saw_busy = 1'b1;
      end
      checks++;
      if (!saw_busy || cur_dir !== 3'd2) begin
         errors++; $display("FAIL release_back got busy_seen=%b dir=%0d expected 1 and 2", saw_busy, cur_dir);
      end
   endtask

   task automatic test_duty_down();
      int on_cnt;
      logic busy_seen;
      cmd_valid = 1'b1; cmd_dir = 3'd1; cmd_duty = 4'd12;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         checks++;
         if (obs !== m_exp) begin
            errors++; $display("FAIL model_d12 t=%0t got %b expected %b", $time, obs, m_exp);
         end
      end
      on_cnt = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         if (hbridge1a) on_cnt++;
      end
      checks++;
      if (on_cnt != 12) begin
         errors++; $display("FAIL duty12_on got %0d expected 12", on_cnt);
      end
      cmd_valid = 1'b1; cmd_dir = 3'd1; cmd_duty = 4'd4;
      repeat (3) @(negedge clk) cmd_valid = 1'b0;
      on_cnt = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         if (hbridge1a) on_cnt++;
      end
      checks++;
      if (on_cnt != 4) begin
         errors++; $display("FAIL duty_down_on got %0d expected 4", on_cnt);
      end
      busy_seen = 0;
      cmd_valid = 1'b1; cmd_dir = 3'd6; cmd_duty = 4'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (busy) busy_seen = 1'b1;
      end
      checks++;
      if (pins !== 4'b0000 || busy_seen || cur_dir !== 3'd0) begin
         errors++; $display("FAIL dir6_stop got pins=%b busy_seen=%b dir=%0d expected 0000 0 0", pins, busy_seen, cur_dir);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== m_exp) begin
            errors++; $display("FAIL model_stop t=%0t got %b expected %b", $time, obs, m_exp);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] last_nz;
      int zrun, len;
      last_nz = 4'b0000; zrun = 0;
      for (int seg = 0; seg < 100; seg++) begin
         len = int'($urandom_range(30, 50));
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_exp) begin
               errors++; $display("FAIL model_rand t=%0t got %b expected %b", $time, obs, m_exp);
            end
            checks++;
            if ((hbridge1a && hbridge1b) || (hbridge2a && hbridge2b)) begin
               errors++; $display("FAIL shoot_through t=%0t got %b expected no leg pair high", $time, pins);
            end
            if (pins == 4'b0000) begin
               zrun++;
            end else begin
               if (last_nz != 4'b0000 && pins != last_nz) begin
                  checks++;
                  if (zrun < 8) begin
                     errors++; $display("FAIL dead_gap t=%0t got %0d zero clk expected >=8", $time, zrun);
                  end
               end
               last_nz = pins; zrun = 0;
            end
            cmd_valid = 1'b0;
            if (c == 0) begin
               cmd_valid = 1'b1;
               cmd_dir   = 3'($urandom_range(0, 7));
               cmd_duty  = 4'($urandom_range(0, 15));
            end
            if (c == 15) begin
               btnU = ($urandom_range(0, 3) == 0);
               btnD = ($urandom_range(0, 3) == 0);
               btnL = ($urandom_range(0, 3) == 0);
               btnR = ($urandom_range(0, 3) == 0);
            end
         end
      end
      btnU = 0; btnD = 0; btnL = 0; btnR = 0; cmd_valid = 0;
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_reversal();
      test_buttons();
      test_duty_down();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
